// File: rtl/spi_regbank_pkg.sv
// Shared types for the SPI register bank: frame FSM states and frame length helper.
package spi_regbank_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HDR,
      ST_DATA,
      ST_DONE
   } state_t;

   // One R/W bit, then the address, then the data word.
   function automatic int flen(input int addr_w, input int data_w);
      return 1 + addr_w + data_w;
   endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser into the system clock plus a third flop for edge detection.
module spi_sync_edge (
   input  logic i_clk,
   input  logic i_async,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic r_meta;
   logic r_sync;
   logic r_prev;

   // Deliberately not reset: a cs held active across reset must not look like a new assertion.
   always_ff @(posedge i_clk) begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
   end

   assign o_level = r_sync;
   assign o_rise  = r_sync & ~r_prev;
   assign o_fall  = ~r_sync & r_prev;

endmodule

// File: rtl/spi_regbank.sv
// SPI-slave register bank: oversampled SPI frame decoder, RW registers with write strobes, RO readback.
module spi_regbank
   import spi_regbank_pkg::*;
#(
   parameter int              ADDR_W         = 6,
   parameter int              DATA_W         = 16,
   parameter int              N_RW           = 8,
   parameter int              N_RO           = 4,
   parameter int              RO_BASE        = 32,
   parameter logic [DATA_W-1:0] RESET_VAL    = '0,
   parameter int              CS_ACTIVE_HIGH = 1
) (
   input  logic                     sys_clk,
   input  logic                     sys_rst_n,
   input  logic                     spi_clk,
   input  logic                     mosi,
   input  logic                     cs,
   output logic                     miso,
   output logic [N_RW*DATA_W-1:0]   rw_regs,
   output logic [N_RW-1:0]          wr_stb,
   input  logic [N_RO*DATA_W-1:0]   ro_in
);

   localparam int FLEN  = flen(ADDR_W, DATA_W);
   localparam int CNT_W = $clog2(FLEN + 1);

   if (RO_BASE + N_RO > (1 << ADDR_W)) begin : g_bad_ro_range
      $error("spi_regbank: read-only window exceeds the address space");
   end
   if (RO_BASE < N_RW) begin : g_bad_ro_base
      $error("spi_regbank: read-only window overlaps the read-write registers");
   end

   logic w_cs_act;
   logic w_cs_lvl, w_cs_rise, w_unused_cs_fall;
   logic w_unused_sck_lvl, w_sck_rise, w_sck_fall;
   logic w_mosi, w_unused_mosi_rise, w_unused_mosi_fall;

   assign w_cs_act = (CS_ACTIVE_HIGH != 0) ? cs : ~cs;

   spi_sync_edge u_sync_cs (
      .i_clk(sys_clk), .i_async(w_cs_act),
      .o_level(w_cs_lvl), .o_rise(w_cs_rise), .o_fall(w_unused_cs_fall));
   spi_sync_edge u_sync_sck (
      .i_clk(sys_clk), .i_async(spi_clk),
      .o_level(w_unused_sck_lvl), .o_rise(w_sck_rise), .o_fall(w_sck_fall));
   spi_sync_edge u_sync_mosi (
      .i_clk(sys_clk), .i_async(mosi),
      .o_level(w_mosi), .o_rise(w_unused_mosi_rise), .o_fall(w_unused_mosi_fall));

   state_t              r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_rw;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_data;
   logic [DATA_W-1:0]   r_tx;
   logic                r_miso;
   logic                r_commit;
   logic [DATA_W-1:0]   r_regs [N_RW];
   logic [N_RW-1:0]     r_wr_stb;

   logic [ADDR_W-1:0]   w_addr_next;
   logic [DATA_W-1:0]   w_rb;

   assign w_addr_next = {r_addr[ADDR_W-2:0], w_mosi};

   // Readback is decoded from the address as it completes, so the load can happen on that same edge.
   always_comb begin
      w_rb = '0;
      for (int k = 0; k < N_RW; k++) begin
         if (w_addr_next == ADDR_W'(k)) w_rb = r_regs[k];
      end
      for (int k = 0; k < N_RO; k++) begin
         if (w_addr_next == ADDR_W'(RO_BASE + k)) w_rb = ro_in[k*DATA_W +: DATA_W];
      end
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_rw     <= 1'b0;
         r_addr   <= '0;
         r_data   <= '0;
         r_tx     <= '0;
         r_miso   <= 1'b0;
         r_commit <= 1'b0;
      end else begin
         r_commit <= 1'b0;
         if (!w_cs_lvl) begin
            r_state <= ST_IDLE;
            r_miso  <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (w_cs_rise) begin
                     r_state <= ST_HDR;
                     r_cnt   <= '0;
                  end
               end
               ST_HDR: begin
                  if (w_sck_rise) begin
                     r_cnt <= r_cnt + 1'b1;
                     if (r_cnt == '0) r_rw   <= w_mosi;
                     else             r_addr <= w_addr_next;
                     if (r_cnt == CNT_W'(ADDR_W)) begin
                        r_tx    <= w_rb;
                        r_miso  <= w_rb[DATA_W-1];
                        r_state <= ST_DATA;
                     end
                  end
               end
               ST_DATA: begin
                  // tx advances on the capture edge; miso follows on the next falling edge.
                  if (w_sck_rise) begin
                     r_cnt  <= r_cnt + 1'b1;
                     r_data <= {r_data[DATA_W-2:0], w_mosi};
                     r_tx   <= r_tx << 1;
                     if (r_cnt == CNT_W'(FLEN - 1)) begin
                        r_state  <= ST_DONE;
                        r_miso   <= 1'b0;
                        r_commit <= r_rw;
                     end
                  end else if (w_sck_fall) begin
                     r_miso <= r_tx[DATA_W-1];
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Unmapped or read-only addresses match no register here, so they commit nothing.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         for (int k = 0; k < N_RW; k++) r_regs[k] <= RESET_VAL;
         r_wr_stb <= '0;
      end else begin
         r_wr_stb <= '0;
         if (r_commit) begin
            for (int k = 0; k < N_RW; k++) begin
               if (r_addr == ADDR_W'(k)) begin
                  r_regs[k]   <= r_data;
                  r_wr_stb[k] <= 1'b1;
               end
            end
         end
      end
   end

   for (genvar k = 0; k < N_RW; k++) begin : g_out
      assign rw_regs[k*DATA_W +: DATA_W] = r_regs[k];
   end

   assign wr_stb = r_wr_stb;
   assign miso   = r_miso;

endmodule
